// File: rtl/bullet_pool_if.sv
// rtl/bullet_pool_if.sv - player/keyboard/pixel inputs and bullet render outputs of bullet_pool
// master drives player and pixel inputs; slave is the bullet pool itself.
interface bullet_pool_if #(
  parameter int NUM_BULLETS = 4,
  parameter int ADDR_W      = 8
);
  logic [7:0]             keycode;
  logic [9:0]             Player_X;
  logic [9:0]             Player_Y;
  logic [1:0]             Player_Direction;
  logic [9:0]             PixelX;
  logic [9:0]             PixelY;
  logic                   is_obj;
  logic [ADDR_W-1:0]      Obj_address;
  logic [NUM_BULLETS-1:0] active_mask;
  logic                   fire_pulse;

  modport master (
    output keycode, Player_X, Player_Y, Player_Direction, PixelX, PixelY,
    input  is_obj, Obj_address, active_mask, fire_pulse
  );

  modport slave (
    input  keycode, Player_X, Player_Y, Player_Direction, PixelX, PixelY,
    output is_obj, Obj_address, active_mask, fire_pulse
  );
endinterface

// File: rtl/bullet_pool.sv
// rtl/bullet_pool.sv - multi-slot projectile manager: spawn, move, retire and render bullets
// State advances only on the divided frame tick; rendering is combinational from slot state.
module bullet_pool #(
  parameter int         NUM_BULLETS = 4,
  parameter int         SIZE        = 16,
  parameter int         SPEED       = 4,
  parameter int         FRAME_DIV   = 1,
  parameter int         COOLDOWN    = 8,
  parameter logic [7:0] FIRE_KEY    = 8'd44,
  parameter int         OFFSET_X    = 5,
  parameter int         OFFSET_Y    = 40,
  parameter int         SCREEN_W    = 640,
  parameter int         SCREEN_H    = 480
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         frame_clk,
  bullet_pool_if.slave bus
);
  localparam int LOG_SIZE = $clog2(SIZE);
  localparam int ADDR_W   = 2 * LOG_SIZE;
  localparam int CD_W     = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  localparam logic [10:0] SIZE11   = 11'(SIZE);
  localparam logic [10:0] SPEED11  = 11'(SPEED);
  localparam logic [9:0]  SPEED10  = 10'(SPEED);
  localparam logic [10:0] SCR_W11  = 11'(SCREEN_W);
  localparam logic [10:0] SCR_H11  = 11'(SCREEN_H);
  localparam logic [10:0] OFF_X11  = 11'(OFFSET_X);
  localparam logic [10:0] OFF_Y11  = 11'(OFFSET_Y);
  localparam logic [3:0]  DIV_LAST = 4'(FRAME_DIV - 1);

  logic                   frame_q, frame_prev_q, tick_q;
  logic [3:0]             div_q;
  logic [NUM_BULLETS-1:0] valid_q, valid_d;
  logic [9:0]             x_q [NUM_BULLETS];
  logic [9:0]             x_d [NUM_BULLETS];
  logic [9:0]             y_q [NUM_BULLETS];
  logic [9:0]             y_d [NUM_BULLETS];
  logic [1:0]             dir_q [NUM_BULLETS];
  logic [1:0]             dir_d [NUM_BULLETS];
  logic [CD_W-1:0]        cd_q, cd_d;
  logic                   fire_pulse_q, fire_pulse_d;

  logic [10:0]            spawn_x, spawn_y;
  logic                   spawn_ok, fire_req, taken;
  logic                   hit;
  logic [ADDR_W-1:0]      addr;
  logic [LOG_SIZE-1:0]    dx, dy;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_q      <= 1'b0;
      frame_prev_q <= 1'b0;
      tick_q       <= 1'b0;
      div_q        <= '0;
      valid_q      <= '0;
      cd_q         <= '0;
      fire_pulse_q <= 1'b0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        x_q[i]   <= '0;
        y_q[i]   <= '0;
        dir_q[i] <= '0;
      end
    end else begin
      frame_q      <= frame_clk;
      frame_prev_q <= frame_q;
      tick_q       <= 1'b0;
      if (frame_q && !frame_prev_q) begin
        if (div_q == DIV_LAST) begin
          div_q  <= '0;
          tick_q <= 1'b1;
        end else begin
          div_q <= div_q + 4'd1;
        end
      end
      valid_q      <= valid_d;
      x_q          <= x_d;
      y_q          <= y_d;
      dir_q        <= dir_d;
      cd_q         <= cd_d;
      fire_pulse_q <= fire_pulse_d;
    end
  end

  always_comb begin
    valid_d      = valid_q;
    x_d          = x_q;
    y_d          = y_q;
    dir_d        = dir_q;
    cd_d         = cd_q;
    fire_pulse_d = 1'b0;
    taken        = 1'b0;
    fire_req     = (bus.keycode == FIRE_KEY);
    spawn_x      = {1'b0, bus.Player_X} + OFF_X11;
    spawn_y      = {1'b0, bus.Player_Y} + OFF_Y11;
    spawn_ok     = (spawn_x + SIZE11 <= SCR_W11) && (spawn_y + SIZE11 <= SCR_H11);
    if (tick_q) begin
      for (int i = 0; i < NUM_BULLETS; i++) begin
        if (valid_q[i]) begin
          unique case (dir_q[i])
            2'd0: if ({1'b0, y_q[i]} < SPEED11) valid_d[i] = 1'b0;
                  else y_d[i] = y_q[i] - SPEED10;
            2'd1: if ({1'b0, x_q[i]} + SPEED11 + SIZE11 > SCR_W11) valid_d[i] = 1'b0;
                  else x_d[i] = x_q[i] + SPEED10;
            2'd2: if ({1'b0, y_q[i]} + SPEED11 + SIZE11 > SCR_H11) valid_d[i] = 1'b0;
                  else y_d[i] = y_q[i] + SPEED10;
            default: if ({1'b0, x_q[i]} < SPEED11) valid_d[i] = 1'b0;
                     else x_d[i] = x_q[i] - SPEED10;
          endcase
        end
      end
      // Allocation sees post-move validity so a slot retired this tick is reusable.
      if (fire_req && cd_q == '0 && spawn_ok) begin
        for (int i = 0; i < NUM_BULLETS; i++) begin
          if (!valid_d[i] && !taken) begin
            taken      = 1'b1;
            valid_d[i] = 1'b1;
            x_d[i]     = spawn_x[9:0];
            y_d[i]     = spawn_y[9:0];
            dir_d[i]   = bus.Player_Direction;
          end
        end
      end
      if (taken) begin
        cd_d         = CD_W'(COOLDOWN);
        fire_pulse_d = 1'b1;
      end else if (cd_q != '0) begin
        cd_d = cd_q - 1'b1;
      end
    end
  end

  always_comb begin
    hit  = 1'b0;
    addr = '0;
    dx   = '0;
    dy   = '0;
    // Walk from the top index down so the lowest hitting slot overrides.
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      if (valid_q[i] &&
          bus.PixelX >= x_q[i] && {1'b0, bus.PixelX} < {1'b0, x_q[i]} + SIZE11 &&
          bus.PixelY >= y_q[i] && {1'b0, bus.PixelY} < {1'b0, y_q[i]} + SIZE11) begin
        hit  = 1'b1;
        dx   = bus.PixelX[LOG_SIZE-1:0] - x_q[i][LOG_SIZE-1:0];
        dy   = bus.PixelY[LOG_SIZE-1:0] - y_q[i][LOG_SIZE-1:0];
        addr = {dy, dx};
      end
    end
  end

  assign bus.is_obj      = hit;
  assign bus.Obj_address = addr;
  assign bus.active_mask = valid_q;
  assign bus.fire_pulse  = fire_pulse_q;

endmodule

// File: tb/tb_bullet_pool.sv
// tb/tb_bullet_pool.sv - self-checking bench for bullet_pool (COOLDOWN 8 and 0 instances)
// Both instances share stimulus; a slot-level behavioural model predicts each one.
module tb_bullet_pool;
  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_clk = 1'b0;
  logic [7:0] keycode = 8'd0;
  logic [9:0] plx = 10'd0, ply = 10'd0, pixx = 10'd0, pixy = 10'd0;
  logic [1:0] pdir = 2'd0;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  bullet_pool_if #(.NUM_BULLETS(4), .ADDR_W(8)) bus0 ();
  bullet_pool_if #(.NUM_BULLETS(4), .ADDR_W(8)) bus1 ();

  assign bus0.keycode = keycode;  assign bus1.keycode = keycode;
  assign bus0.Player_X = plx;     assign bus1.Player_X = plx;
  assign bus0.Player_Y = ply;     assign bus1.Player_Y = ply;
  assign bus0.Player_Direction = pdir; assign bus1.Player_Direction = pdir;
  assign bus0.PixelX = pixx;      assign bus1.PixelX = pixx;
  assign bus0.PixelY = pixy;      assign bus1.PixelY = pixy;

  bullet_pool #(.COOLDOWN(8)) u_dut0 (.Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .bus(bus0));
  bullet_pool #(.COOLDOWN(0)) u_dut1 (.Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .bus(bus1));

  logic [3:0] mask_o [2];
  logic       fp_o   [2];
  logic       obj_o  [2];
  logic [7:0] addr_o [2];
  assign mask_o[0] = bus0.active_mask; assign mask_o[1] = bus1.active_mask;
  assign fp_o[0]   = bus0.fire_pulse;  assign fp_o[1]   = bus1.fire_pulse;
  assign obj_o[0]  = bus0.is_obj;      assign obj_o[1]  = bus1.is_obj;
  assign addr_o[0] = bus0.Obj_address; assign addr_o[1] = bus1.Obj_address;

  // Behavioural model: one record per slot, stepped once per tick.
  int  cd_max [2] = '{8, 0};
  bit  m_valid [2][4];
  int  m_x [2][4];
  int  m_y [2][4];
  int  m_dir [2][4];
  int  m_cd [2];
  bit  exp_fire [2];
  logic fp_up [2];
  logic fp_after [2];

  function automatic logic [3:0] exp_mask(int k);
    logic [3:0] m;
    for (int i = 0; i < 4; i++) m[i] = m_valid[k][i];
    return m;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cd[k] = 0;
      exp_fire[k] = 0;
      for (int i = 0; i < 4; i++) begin
        m_valid[k][i] = 0; m_x[k][i] = 0; m_y[k][i] = 0; m_dir[k][i] = 0;
      end
    end
  endtask

  task automatic model_tick();
    int sx, sy;
    sx = int'(plx) + 5;
    sy = int'(ply) + 40;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        if (m_valid[k][i]) begin
          case (m_dir[k][i])
            0: if (m_y[k][i] < 4) m_valid[k][i] = 0; else m_y[k][i] -= 4;
            1: if (m_x[k][i] + 20 > 640) m_valid[k][i] = 0; else m_x[k][i] += 4;
            2: if (m_y[k][i] + 20 > 480) m_valid[k][i] = 0; else m_y[k][i] += 4;
            default: if (m_x[k][i] < 4) m_valid[k][i] = 0; else m_x[k][i] -= 4;
          endcase
        end
      end
      exp_fire[k] = 0;
      if (keycode == 8'd44 && m_cd[k] == 0) begin
        if (sx + 16 <= 640 && sy + 16 <= 480) begin
          for (int i = 0; i < 4; i++) begin
            if (!m_valid[k][i] && !exp_fire[k]) begin
              m_valid[k][i] = 1; m_x[k][i] = sx; m_y[k][i] = sy; m_dir[k][i] = int'(pdir);
              exp_fire[k] = 1;
            end
          end
          if (exp_fire[k]) m_cd[k] = cd_max[k];
        end
      end else if (m_cd[k] > 0) begin
        m_cd[k] -= 1;
      end
    end
  endtask

  task automatic model_pixel(input int k, input int px, input int py, output bit hit, output int addr);
    hit = 0;
    addr = 0;
    for (int i = 0; i < 4; i++) begin
      if (!hit && m_valid[k][i] && px >= m_x[k][i] && px < m_x[k][i] + 16 &&
          py >= m_y[k][i] && py < m_y[k][i] + 16) begin
        hit = 1;
        addr = ((py - m_y[k][i]) * 16 + (px - m_x[k][i])) % 256;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge Clk);
    Reset_n = 1'b0;
    frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    model_reset();
  endtask

  task automatic do_tick();
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    fp_up[0] = fp_o[0]; fp_up[1] = fp_o[1];
    @(posedge Clk);
    #1;
    fp_after[0] = fp_o[0]; fp_after[1] = fp_o[1];
    @(negedge Clk);
    frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
    model_tick();
  endtask

  task automatic test_reset();
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (mask_o[k] !== 4'h0 || fp_o[k] !== 1'b0 || obj_o[k] !== 1'b0 || addr_o[k] !== 8'h00) begin
        errors++;
        $display("FAIL reset inst%0d: mask=%h fp=%b obj=%b addr=%h, required 0/0/0/0", k, mask_o[k], fp_o[k], obj_o[k], addr_o[k]);
      end
    end
  endtask

  task automatic test_single_fire();
    apply_reset();
    plx = 10'd100; ply = 10'd100; pdir = 2'd1; keycode = 8'd44;
    do_tick();
    keycode = 8'd0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (mask_o[k] !== 4'b0001 || fp_up[k] !== 1'b1 || fp_after[k] !== 1'b0) begin
        errors++;
        $display("FAIL single_fire inst%0d: mask=%b fp=%b/%b, required 0001 1/0", k, mask_o[k], fp_up[k], fp_after[k]);
      end
    end
    pixx = 10'd105; pixy = 10'd140; #1;
    checks++;
    if (obj_o[0] !== 1'b1 || addr_o[0] !== 8'd0) begin
      errors++;
      $display("FAIL spawn_corner: obj=%b addr=%0d, required 1 0", obj_o[0], addr_o[0]);
    end
    pixx = 10'd120; pixy = 10'd155; #1;
    checks++;
    if (obj_o[0] !== 1'b1 || addr_o[0] !== 8'd255) begin
      errors++;
      $display("FAIL spawn_far_corner: obj=%b addr=%0d, required 1 255", obj_o[0], addr_o[0]);
    end
    pixx = 10'd121; #1;
    checks++;
    if (obj_o[0] !== 1'b0 || addr_o[0] !== 8'd0) begin
      errors++;
      $display("FAIL right_of_sprite: obj=%b addr=%0d, required 0 0", obj_o[0], addr_o[0]);
    end
    do_tick();
    pixx = 10'd109; pixy = 10'd140; #1;
    checks++;
    if (obj_o[0] !== 1'b1 || addr_o[0] !== 8'd0 || fp_up[0] !== 1'b0) begin
      errors++;
      $display("FAIL moved_x109: obj=%b addr=%0d fp=%b, required 1 0 0", obj_o[0], addr_o[0], fp_up[0]);
    end
    pixx = 10'd108; #1;
    checks++;
    if (obj_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL left_of_moved: obj=%b, required 0", obj_o[0]);
    end
  endtask

  task automatic test_cooldown();
    apply_reset();
    plx = 10'd100; ply = 10'd100; pdir = 2'd1; keycode = 8'd44;
    for (int t = 0; t < 20; t++) begin
      do_tick();
      checks++;
      if (fp_up[0] !== ((t == 0 || t == 9 || t == 18) ? 1'b1 : 1'b0) || mask_o[0] !== exp_mask(0)) begin
        errors++;
        $display("FAIL cooldown t=%0d: fp=%b mask=%b, required fp=%b mask=%b", t, fp_up[0], mask_o[0], (t == 0 || t == 9 || t == 18), exp_mask(0));
      end
      checks++;
      if (fp_up[1] !== exp_fire[1] || mask_o[1] !== exp_mask(1)) begin
        errors++;
        $display("FAIL nocooldown t=%0d: fp=%b mask=%b, required fp=%b mask=%b", t, fp_up[1], mask_o[1], exp_fire[1], exp_mask(1));
      end
    end
    checks++;
    if (mask_o[0] !== 4'b0111) begin
      errors++;
      $display("FAIL cooldown_final_mask: mask=%b, required 0111", mask_o[0]);
    end
    keycode = 8'd0;
  endtask

  task automatic test_pool_full();
    apply_reset();
    plx = 10'd300; ply = 10'd400; pdir = 2'd0; keycode = 8'd44;
    for (int t = 0; t < 6; t++) begin
      do_tick();
      checks++;
      if (fp_up[1] !== ((t < 4) ? 1'b1 : 1'b0) || fp_after[1] !== 1'b0 || mask_o[1] !== exp_mask(1)) begin
        errors++;
        $display("FAIL pool_full t=%0d: fp=%b/%b mask=%b, required fp=%b/0 mask=%b", t, fp_up[1], fp_after[1], mask_o[1], (t < 4), exp_mask(1));
      end
    end
    checks++;
    if (mask_o[1] !== 4'b1111) begin
      errors++;
      $display("FAIL pool_full_mask: mask=%b, required 1111", mask_o[1]);
    end
    keycode = 8'd0;
  endtask

  task automatic test_edge_retire();
    apply_reset();
    plx = 10'd0; ply = 10'd100; pdir = 2'd3; keycode = 8'd44;
    do_tick();
    keycode = 8'd0;
    do_tick();
    pixx = 10'd1; pixy = 10'd140; #1;
    checks++;
    if (obj_o[1] !== 1'b1 || addr_o[1] !== 8'd0 || mask_o[1] !== 4'b0001) begin
      errors++;
      $display("FAIL edge_move_x1: obj=%b addr=%0d mask=%b, required 1 0 0001", obj_o[1], addr_o[1], mask_o[1]);
    end
    keycode = 8'd44;
    do_tick();
    keycode = 8'd0;
    pixx = 10'd5; #1;
    checks++;
    if (fp_up[1] !== 1'b1 || mask_o[1] !== 4'b0001 || obj_o[1] !== 1'b1 || addr_o[1] !== 8'd0) begin
      errors++;
      $display("FAIL edge_reuse: fp=%b mask=%b obj=%b addr=%0d, required 1 0001 1 0", fp_up[1], mask_o[1], obj_o[1], addr_o[1]);
    end
    checks++;
    if (mask_o[0] !== 4'b0000 || fp_up[0] !== 1'b0) begin
      errors++;
      $display("FAIL edge_retire_cooldown: mask=%b fp=%b, required 0000 0", mask_o[0], fp_up[0]);
    end
  endtask

  task automatic test_overlap();
    apply_reset();
    ply = 10'd100; pdir = 2'd1; keycode = 8'd44;
    plx = 10'd100; do_tick();
    plx = 10'd104; do_tick();
    keycode = 8'd0;
    pixx = 10'd112; pixy = 10'd143; #1;
    checks++;
    if (obj_o[1] !== 1'b1 || addr_o[1] !== 8'd51 || mask_o[1] !== 4'b0011) begin
      errors++;
      $display("FAIL overlap_same: obj=%b addr=%0d mask=%b, required 1 51 0011", obj_o[1], addr_o[1], mask_o[1]);
    end
    keycode = 8'd44; plx = 10'd109; do_tick();
    keycode = 8'd0;
    pixx = 10'd115; pixy = 10'd141; #1;
    checks++;
    if (obj_o[1] !== 1'b1 || addr_o[1] !== 8'd18 || mask_o[1] !== 4'b0111) begin
      errors++;
      $display("FAIL overlap_priority: obj=%b addr=%0d mask=%b, required 1 18 0111", obj_o[1], addr_o[1], mask_o[1]);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    plx = 10'd200; ply = 10'd200; pdir = 2'd2; keycode = 8'd44;
    repeat (3) do_tick();
    keycode = 8'd0;
    pixx = 10'd205; pixy = 10'd252; #1;
    checks++;
    if (mask_o[1] !== 4'b0111 || obj_o[1] !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: mask=%b obj=%b, required 0111 1", mask_o[1], obj_o[1]);
    end
    @(posedge Clk);
    #3 Reset_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (mask_o[k] !== 4'h0 || obj_o[k] !== 1'b0) begin
        errors++;
        $display("FAIL async_reset inst%0d: mask=%b obj=%b, required 0000 0", k, mask_o[k], obj_o[k]);
      end
    end
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    bit hit;
    int addr, px, py, s;
    apply_reset();
    for (int t = 0; t < 60; t++) begin
      keycode = ($urandom_range(0, 2) != 0) ? 8'd44 : 8'($urandom_range(0, 43));
      plx = 10'($urandom_range(0, 639));
      ply = 10'($urandom_range(0, 479));
      pdir = 2'($urandom_range(0, 3));
      do_tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (fp_up[k] !== exp_fire[k] || fp_after[k] !== 1'b0 || mask_o[k] !== exp_mask(k)) begin
          errors++;
          $display("FAIL random t=%0d inst%0d: fp=%b/%b mask=%b, required %b/0 %b", t, k, fp_up[k], fp_after[k], mask_o[k], exp_fire[k], exp_mask(k));
        end
      end
      for (int p = 0; p < 3; p++) begin
        s = $urandom_range(0, 3);
        px = m_x[1][s] + $urandom_range(0, 17) - 1;
        py = m_y[1][s] + $urandom_range(0, 17) - 1;
        if (px < 0) px = 0;
        if (py < 0) py = 0;
        pixx = 10'(px); pixy = 10'(py); #1;
        for (int k = 0; k < 2; k++) begin
          model_pixel(k, px, py, hit, addr);
          checks++;
          if (obj_o[k] !== hit || addr_o[k] !== 8'(addr)) begin
            errors++;
            $display("FAIL random_pixel t=%0d inst%0d (%0d,%0d): obj=%b addr=%0d, required %b %0d", t, k, px, py, obj_o[k], addr_o[k], hit, addr);
          end
        end
      end
    end
    keycode = 8'd0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_fire();
    test_cooldown();
    test_pool_full();
    test_edge_retire();
    test_overlap();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bullet_pool.md
# bullet_pool

Parametrised multi-projectile manager for the boxhead player attack. It holds up to NUM_BULLETS independent bullets. Each bullet is spawned at the player on the fire key, travels in the player's facing direction once per frame tick, and retires at the screen edge. The block sits between the keyboard/player logic and the sprite mux, and returns a per-pixel hit flag plus a sprite ROM address for the colour mapper.

## Interface
Parameters:
- NUM_BULLETS, 4, number of bullet slots (1..8)
- SIZE, 16, bullet sprite width and height in pixels (power of two)
- SPEED, 4, pixels moved per tick
- FRAME_DIV, 1, frame_clk rising edges per tick (1..15)
- COOLDOWN, 8, ticks between accepted shots (0 = no cooldown)
- FIRE_KEY, 8'd44, keycode that fires (space)
- OFFSET_X, 5, spawn X offset from Player_X
- OFFSET_Y, 40, spawn Y offset from Player_Y
- SCREEN_W, 640, screen width in pixels
- SCREEN_H, 480, screen height in pixels

Ports:
- Clk  in  1  50 MHz system clock
- Reset_n  in  1  asynchronous, active-low reset
- frame_clk  in  1  ~60 Hz frame strobe
- keycode  in  8  current keycode
- Player_X, Player_Y  in  10 each  player top-left position
- Player_Direction  in  2  0 up, 1 right, 2 down, 3 left
- PixelX, PixelY  in  10 each  current VGA pixel
- is_obj  out  1  current pixel lies on an active bullet
- Obj_address  out  log2(SIZE*SIZE)  sprite ROM address
- active_mask  out  NUM_BULLETS  bit i set while slot i is live
- fire_pulse  out  1  one-cycle strobe when a shot is accepted

## Operation
- Each slot holds: valid, X[9:0], Y[9:0], dir[1:0].
- Tick generation:
  - frame_clk is registered; a rising edge is detected on the next Clk.
  - A divider counts edges 0..FRAME_DIV-1. `tick` is a one-Clk pulse on wrap.
- Fire request: keycode == FIRE_KEY sampled at the tick. Holding the key gives auto-fire, rate-limited by the cooldown.
- On each tick, in this order:
  1. Move every valid slot by SPEED in its dir. A slot retires (valid <= 0) if the move would leave the screen:
     - up: Y < SPEED
     - left: X < SPEED
     - right: X+SPEED+SIZE > SCREEN_W
     - down: Y+SPEED+SIZE > SCREEN_H
  2. If a fire request is present and cooldown == 0, allocate the lowest-index slot that is free after step 1.
     - The new slot gets X = Player_X+OFFSET_X, Y = Player_Y+OFFSET_Y, dir = Player_Direction.
     - cooldown loads COOLDOWN, and fire_pulse asserts.
     - A spawned bullet is not moved in its spawn tick.
  3. Otherwise, decrement cooldown if nonzero (saturates at 0).
- Fire is dropped, with no state change and no cooldown load, when:
  - all slots are valid after step 1, or
  - the spawn box exceeds the screen (X+SIZE > SCREEN_W or Y+SIZE > SCREEN_H).
- A slot retiring in step 1 is reusable in the same tick's step 2.
- Rendering:
  - Combinational from registered state.
  - Slot i hits when X_i ≤ PixelX < X_i+SIZE, Y_i ≤ PixelY < Y_i+SIZE, and valid_i.
  - The lowest-index hitting slot wins.
  - Obj_address = (PixelY−Y_i)*SIZE + (PixelX−X_i), truncated to address width.
  - With no hit: is_obj = 0 and Obj_address = 0.
- Arithmetic: all position sums are computed at 11 bits to avoid 10-bit wrap before comparison.

## Timing
- Reset values: all valid = 0, X/Y/dir = 0, cooldown = 0, divider = 0, fire_pulse = 0, is_obj = 0, Obj_address = 0, active_mask = 0.
- Reset is asynchronous in all flops. Reset asserted mid-flight clears every slot immediately.
- Latency:
  - frame_clk rising to tick: 2 Clk.
  - tick to updated slot state, active_mask and fire_pulse: 1 Clk.
  - Slot state to is_obj/Obj_address: 0 Clk (combinational).
- fire_pulse is high for exactly one Clk per accepted shot. At most one spawn occurs per tick.
- Keycode and player inputs are sampled only on the tick cycle. Values between ticks are ignored.

## Test plan
- Reset then single fire: Reset_n low→high, Player (100,100), dir 1, keycode 44 held for one tick.
  - Expect slot 0 at (105,140), active_mask = 0001, fire_pulse for 1 Clk.
  - Next tick: X = 109. Pixel (105,140) gives is_obj = 1 and address 0 before the move. Pixel (120,155) gives address 255.
- Cooldown and auto-fire: hold key 44 for 20 ticks with COOLDOWN = 8.
  - Expect spawns at ticks 0, 9 and 18 only; active_mask grows 0001→0011→0111.
- Pool full: COOLDOWN = 0, hold fire for 6 ticks with dir 0 from Player (300,400).
  - Expect 4 spawns (mask 1111), then dropped fires with no fire_pulse and no cooldown change.
- Edge retire and reuse: fire left from Player_X = 0 (spawn X = 5).
  - Expect a move to X = 1; the next tick retires the slot (1 < 4), mask bit clears.
  - A fire request on that same tick reuses slot 0.
- Overlap priority: two bullets at identical coordinates. Expect is_obj = 1 with the address taken from slot 0.
- Asynchronous reset mid-flight: assert Reset_n low between Clk edges with 3 active bullets.
  - Expect active_mask = 0 and is_obj = 0 immediately, without waiting for a Clk edge.
